// File: rtl/ram_port_arb_pkg.sv
// rtl/ram_port_arb_pkg.sv - shared defaults and state encoding for the RAM port arbiter
//
// Purpose: default widths and burst limit, plus the owner-state encoding used
//          by the arbiter FSM.
// Ports:   none (package).
package ram_port_arb_pkg;

   localparam int DEF_ADDR_W    = 20;
   localparam int DEF_DATA_W    = 24;
   localparam int DEF_MAX_BURST = 64;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      OWN0 = 2'd1,
      OWN1 = 2'd2
   } arb_state_t;

endpackage

// File: rtl/ram_port_arb_rr_pick2.sv
// rtl/ram_port_arb_rr_pick2.sv - two-way round-robin pick
//
// Purpose: picks one of two requesters; on a tie the port that was NOT last
//          served wins.
// Ports:   req[1:0] - request per port (bit n = port n)
//          ptr      - last-served port
//          pick[1:0]- one-hot (or zero) selection
module rr_pick2 (
   input  logic [1:0] req,
   input  logic       ptr,
   output logic [1:0] pick
);

   always_comb begin
      pick = req;
      if (req == 2'b11) begin
         pick = ptr ? 2'b01 : 2'b10;
      end
   end

endmodule

// File: rtl/ram_port_arb.sv
// rtl/ram_port_arb.sv - two-port arbiter in front of a single-port RAM macro
//
// Purpose: shares one single-port RAM between two requesters with
//          round-robin tie-breaking, locked bursts limited to MAX_BURST grants
//          while the other port waits, and a one-cycle tagged read-return pipe.
// Ports:   clk, rst                 - clock, synchronous active-high reset
//          Pn_REQ/WE/LOCK/A/D       - per-port request, write enable, burst
//                                     lock, address, write data
//          Pn_GNT                   - access accepted this cycle (combinational)
//          Pn_RVALID, RDATA         - read return, one cycle after a read grant
//          RAM_A/D/WE/OE, RAM_Q     - RAM macro interface (Q one cycle after OE)
module ram_port_arb
   import ram_port_arb_pkg::*;
#(
   parameter int ADDR_W    = DEF_ADDR_W,
   parameter int DATA_W    = DEF_DATA_W,
   parameter int MAX_BURST = DEF_MAX_BURST
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              P0_REQ,
   input  logic              P0_WE,
   input  logic              P0_LOCK,
   input  logic [ADDR_W-1:0] P0_A,
   input  logic [DATA_W-1:0] P0_D,
   input  logic              P1_REQ,
   input  logic              P1_WE,
   input  logic              P1_LOCK,
   input  logic [ADDR_W-1:0] P1_A,
   input  logic [DATA_W-1:0] P1_D,
   output logic              P0_GNT,
   output logic              P1_GNT,
   output logic              P0_RVALID,
   output logic              P1_RVALID,
   output logic [DATA_W-1:0] RDATA,
   output logic [ADDR_W-1:0] RAM_A,
   output logic [DATA_W-1:0] RAM_D,
   output logic              RAM_WE,
   output logic              RAM_OE,
   input  logic [DATA_W-1:0] RAM_Q
);

   localparam int CNT_W = $clog2(MAX_BURST + 1);

   arb_state_t        state, state_nxt;
   logic              ptr, ptr_nxt;
   logic [CNT_W-1:0]  cnt, cnt_nxt;
   logic [1:0]        rv, rv_nxt;

   logic [1:0]        req;
   logic [1:0]        idle_pick;
   logic [1:0]        gnt;

   logic              lock_g;
   logic              other_req;
   logic              same_owner;
   logic              limit_hit;
   logic [CNT_W-1:0]  cnt_inc;

   assign req = {P1_REQ, P0_REQ};

   rr_pick2 u_pick (
      .req  (req),
      .ptr  (ptr),
      .pick (idle_pick)
   );

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         ptr   <= 1'b1;
         cnt   <= '0;
         rv    <= 2'b00;
      end else begin
         state <= state_nxt;
         ptr   <= ptr_nxt;
         cnt   <= cnt_nxt;
         rv    <= rv_nxt;
      end
   end

   // Next-state logic
   always_comb begin
      lock_g     = gnt[1] ? P1_LOCK : P0_LOCK;
      other_req  = gnt[1] ? P0_REQ  : P1_REQ;
      same_owner = (gnt[0] && (state == OWN0)) || (gnt[1] && (state == OWN1));

      // Saturate so a long uncontested burst cannot wrap back below the limit.
      if (same_owner) begin
         cnt_inc = (cnt == CNT_W'(MAX_BURST)) ? cnt : cnt + CNT_W'(1);
      end else begin
         cnt_inc = CNT_W'(1);
      end
      limit_hit = (cnt_inc >= CNT_W'(MAX_BURST)) && other_req;

      state_nxt = IDLE;
      ptr_nxt   = ptr;
      cnt_nxt   = '0;
      if (gnt != 2'b00) begin
         if (lock_g && !limit_hit) begin
            state_nxt = gnt[1] ? OWN1 : OWN0;
            cnt_nxt   = cnt_inc;
         end else begin
            // Dropping to IDLE with ptr = owner hands the next tie to the other port.
            ptr_nxt = gnt[1];
         end
      end

      // Read return is tagged by the port that issued it, not by the next grant.
      rv_nxt = {gnt[1] & ~P1_WE, gnt[0] & ~P0_WE};
   end

   // Output logic: grant selection and RAM port mux
   always_comb begin
      gnt = 2'b00;
      if (!rst) begin
         case (state)
            OWN0:    gnt = P0_REQ ? 2'b01 : (P1_REQ ? 2'b10 : 2'b00);
            OWN1:    gnt = P1_REQ ? 2'b10 : (P0_REQ ? 2'b01 : 2'b00);
            default: gnt = idle_pick;
         endcase
      end

      RAM_A  = '0;
      RAM_D  = '0;
      RAM_WE = 1'b0;
      RAM_OE = 1'b0;
      if (gnt[0]) begin
         RAM_A  = P0_A;
         RAM_D  = P0_D;
         RAM_WE = P0_WE;
         RAM_OE = ~P0_WE;
      end else if (gnt[1]) begin
         RAM_A  = P1_A;
         RAM_D  = P1_D;
         RAM_WE = P1_WE;
         RAM_OE = ~P1_WE;
      end
   end

   assign P0_GNT    = gnt[0];
   assign P1_GNT    = gnt[1];
   // Gated by rst so a read in flight when reset arrives never shows up.
   assign P0_RVALID = rv[0] & ~rst;
   assign P1_RVALID = rv[1] & ~rst;
   assign RDATA     = ((rv != 2'b00) && !rst) ? RAM_Q : '0;

endmodule

// File: tb/tb_ram_port_arb.sv
// tb/tb_ram_port_arb.sv - directed and randomized self-checking bench for ram_port_arb
module tb_ram_port_arb;

   localparam int AW = 8;
   localparam int DW = 24;
   localparam int MB = 64;

   logic          clk = 1'b0;
   logic          rst;
   logic          P0_REQ, P0_WE, P0_LOCK;
   logic [AW-1:0] P0_A;
   logic [DW-1:0] P0_D;
   logic          P1_REQ, P1_WE, P1_LOCK;
   logic [AW-1:0] P1_A;
   logic [DW-1:0] P1_D;
   logic          P0_GNT, P1_GNT, P0_RVALID, P1_RVALID;
   logic [DW-1:0] RDATA;
   logic [AW-1:0] RAM_A;
   logic [DW-1:0] RAM_D;
   logic          RAM_WE, RAM_OE;
   logic [DW-1:0] ram_q;

   logic [DW-1:0] mem [0:255];
   logic [DW-1:0] sh  [0:255];
   logic [61:0]   outs;

   int            ntests = 0;
   int            nfail  = 0;
   int            p0n;
   int            w0, w1;
   logic          exp_rv0, exp_rv1, g0, g1;
   logic [DW-1:0] exp_rd;
   logic [1:0]    exp_g;

   always #5 clk = ~clk;

   ram_port_arb #(.ADDR_W(AW), .DATA_W(DW), .MAX_BURST(MB)) dut (
      .clk(clk), .rst(rst),
      .P0_REQ(P0_REQ), .P0_WE(P0_WE), .P0_LOCK(P0_LOCK), .P0_A(P0_A), .P0_D(P0_D),
      .P1_REQ(P1_REQ), .P1_WE(P1_WE), .P1_LOCK(P1_LOCK), .P1_A(P1_A), .P1_D(P1_D),
      .P0_GNT(P0_GNT), .P1_GNT(P1_GNT), .P0_RVALID(P0_RVALID), .P1_RVALID(P1_RVALID),
      .RDATA(RDATA), .RAM_A(RAM_A), .RAM_D(RAM_D), .RAM_WE(RAM_WE), .RAM_OE(RAM_OE),
      .RAM_Q(ram_q)
   );

   // Single-port RAM model: write at the edge, read data one cycle after OE.
   always @(posedge clk) begin
      if (RAM_WE) mem[RAM_A] <= RAM_D;
      if (RAM_OE) ram_q <= mem[RAM_A];
   end

   assign outs = {P0_GNT, P1_GNT, P0_RVALID, P1_RVALID, RAM_WE, RAM_OE, RAM_A, RAM_D, RDATA};

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      ntests++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic idle_in();
      P0_REQ = 0; P0_WE = 0; P0_LOCK = 0; P0_A = '0; P0_D = '0;
      P1_REQ = 0; P1_WE = 0; P1_LOCK = 0; P1_A = '0; P1_D = '0;
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset: outputs quiet even with requests present
      rst = 1'b1;
      idle_in();
      next_cycle();
      next_cycle();
      P0_REQ = 1; P1_REQ = 1; P0_WE = 1;
      @(negedge clk);
      chk("rst_outs", 64'(outs), 64'(0));
      next_cycle();
      rst = 1'b0;
      idle_in();

      // P0-only writes, four consecutive grants
      for (int i = 0; i < 4; i++) begin
         P0_REQ = 1; P0_WE = 1; P0_A = AW'(i); P0_D = DW'(24'h112233 + i);
         @(negedge clk);
         chk("wr_gnt", 64'({P0_GNT, P1_GNT}), 64'(2'b10));
         chk("wr_ram", 64'({RAM_WE, RAM_OE, RAM_A, RAM_D}),
             64'({1'b1, 1'b0, AW'(i), DW'(24'h112233 + i)}));
         chk("wr_norv", 64'({P0_RVALID, P1_RVALID, RDATA}), 64'(0));
         next_cycle();
      end
      idle_in();
      @(negedge clk);
      chk("wr_norv_tail", 64'({P0_RVALID, P1_RVALID, RDATA}), 64'(0));
      for (int i = 0; i < 4; i++) chk("wr_mem", 64'(mem[i]), 64'(24'h112233 + i));
      next_cycle();

      // Both read every cycle after reset: alternate P0, P1, ...
      rst = 1'b1;
      next_cycle();
      rst = 1'b0;
      P0_REQ = 1; P1_REQ = 1; P0_A = 8'd1; P1_A = 8'd3;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         chk("alt_gnt", 64'({P0_GNT, P1_GNT}), 64'((k % 2 == 0) ? 2'b10 : 2'b01));
         chk("alt_ram", 64'({RAM_WE, RAM_OE, RAM_A}),
             64'({1'b0, 1'b1, (k % 2 == 0) ? 8'd1 : 8'd3}));
         if (k == 0) begin
            chk("alt_rv0", 64'({P0_RVALID, P1_RVALID}), 64'(0));
         end else begin
            chk("alt_rv", 64'({P0_RVALID, P1_RVALID}), 64'((k % 2 == 1) ? 2'b10 : 2'b01));
            chk("alt_rd", 64'(RDATA), 64'((k % 2 == 1) ? 24'h112234 : 24'h112236));
         end
         next_cycle();
      end
      idle_in();
      @(negedge clk);
      chk("alt_rv_last", 64'({P0_RVALID, P1_RVALID}), 64'(2'b01));
      chk("alt_rd_last", 64'(RDATA), 64'(24'h112236));
      next_cycle();

      // Locked P0 burst against a waiting P1: 64 P0, 1 P1, then P0 resumes
      p0n = 0;
      P1_REQ = 1; P1_WE = 1; P1_LOCK = 0; P1_A = 8'd200; P1_D = 24'h5A5A5A;
      P0_REQ = 1; P0_WE = 1; P0_LOCK = 1;
      for (int c = 0; c < 101; c++) begin
         P0_A = AW'(16 + p0n);
         P0_D = DW'(p0n);
         exp_g = (c == MB) ? 2'b01 : 2'b10;
         @(negedge clk);
         chk("burst_gnt", 64'({P0_GNT, P1_GNT}), 64'(exp_g));
         if (exp_g == 2'b10) p0n++;
         next_cycle();
         if (c == MB) P1_REQ = 0;
      end
      idle_in();
      next_cycle();
      chk("burst_p1_mem", 64'(mem[200]), 64'(24'h5A5A5A));
      chk("burst_p0_mem63", 64'(mem[16 + 63]), 64'(63));
      chk("burst_p0_mem99", 64'(mem[16 + 99]), 64'(99));

      // P1 read granted, then reset: read dropped, outputs quiet, P0 wins first tie
      P1_REQ = 1; P1_WE = 0; P1_A = 8'd5;
      @(negedge clk);
      chk("rst_rd_gnt", 64'({P1_GNT, RAM_OE}), 64'(2'b11));
      next_cycle();
      rst = 1'b1;
      idle_in();
      @(negedge clk);
      chk("rst_drop", 64'(outs), 64'(0));
      next_cycle();
      P0_REQ = 1; P1_REQ = 1;
      @(negedge clk);
      chk("rst_hold", 64'(outs), 64'(0));
      next_cycle();
      rst = 1'b0;
      P0_A = 8'd2; P1_A = 8'd3;
      @(negedge clk);
      chk("tie_after_rst", 64'({P0_GNT, P1_GNT}), 64'(2'b10));
      chk("no_rv_after_rst", 64'({P0_RVALID, P1_RVALID, RDATA}), 64'(0));
      next_cycle();
      idle_in();
      @(negedge clk);
      chk("tie_rv", 64'({P0_RVALID, P1_RVALID}), 64'(2'b10));
      chk("tie_rd", 64'(RDATA), 64'(24'h112235));
      next_cycle();

      // Write by P0, read-back by P1 the next cycle
      P0_REQ = 1; P0_WE = 1; P0_A = 8'd7; P0_D = 24'hABCDEF;
      @(negedge clk);
      chk("wr7_gnt", 64'({P0_GNT, P1_GNT}), 64'(2'b10));
      next_cycle();
      idle_in();
      P1_REQ = 1; P1_WE = 0; P1_A = 8'd7;
      @(negedge clk);
      chk("rd7_gnt", 64'({P0_GNT, P1_GNT}), 64'(2'b01));
      chk("wr7_norv", 64'({P0_RVALID, P1_RVALID}), 64'(0));
      next_cycle();
      idle_in();
      @(negedge clk);
      chk("rd7_rv", 64'({P0_RVALID, P1_RVALID}), 64'(2'b01));
      chk("rd7_data", 64'(RDATA), 64'(24'hABCDEF));
      next_cycle();

      // Random traffic against a shadow memory and invariant checks
      for (int i = 0; i < 256; i++) sh[i] = mem[i];
      w0 = 0; w1 = 0; exp_rv0 = 0; exp_rv1 = 0; exp_rd = '0;
      for (int n = 0; n < 3000; n++) begin
         if (!P0_REQ && ($urandom_range(1, 0) == 1)) begin
            P0_REQ = 1; P0_WE = 1'($urandom_range(1, 0));
            P0_A = AW'($urandom_range(31, 0)); P0_D = DW'($urandom);
         end
         if (!P1_REQ && ($urandom_range(1, 0) == 1)) begin
            P1_REQ = 1; P1_WE = 1'($urandom_range(1, 0));
            P1_A = AW'($urandom_range(31, 0)); P1_D = DW'($urandom);
         end
         P0_LOCK = ($urandom_range(3, 0) != 0);
         P1_LOCK = ($urandom_range(3, 0) != 0);
         @(negedge clk);
         chk("rnd_rv", 64'({P0_RVALID, P1_RVALID}), 64'({exp_rv0, exp_rv1}));
         chk("rnd_rd", 64'(RDATA), 64'((exp_rv0 | exp_rv1) ? exp_rd : '0));
         chk("rnd_one_gnt", 64'(P0_GNT & P1_GNT), 64'(0));
         chk("rnd_gnt_req", 64'({P0_GNT & ~P0_REQ, P1_GNT & ~P1_REQ}), 64'(0));
         exp_rv0 = 0; exp_rv1 = 0;
         if (P0_GNT) begin
            if (P0_WE) begin
               chk("rnd_ram0w", 64'({RAM_WE, RAM_OE, RAM_A, RAM_D}), 64'({2'b10, P0_A, P0_D}));
               sh[P0_A] = P0_D;
            end else begin
               chk("rnd_ram0r", 64'({RAM_WE, RAM_OE, RAM_A}), 64'({2'b01, P0_A}));
               exp_rv0 = 1; exp_rd = sh[P0_A];
            end
         end else if (P1_GNT) begin
            if (P1_WE) begin
               chk("rnd_ram1w", 64'({RAM_WE, RAM_OE, RAM_A, RAM_D}), 64'({2'b10, P1_A, P1_D}));
               sh[P1_A] = P1_D;
            end else begin
               chk("rnd_ram1r", 64'({RAM_WE, RAM_OE, RAM_A}), 64'({2'b01, P1_A}));
               exp_rv1 = 1; exp_rd = sh[P1_A];
            end
         end else begin
            chk("rnd_ram_idle", 64'({RAM_WE, RAM_OE, RAM_A, RAM_D}), 64'(0));
         end
         w0 = (P0_REQ && !P0_GNT) ? w0 + 1 : 0;
         w1 = (P1_REQ && !P1_GNT) ? w1 + 1 : 0;
         chk("rnd_starve0", 64'(w0 > MB + 1), 64'(0));
         chk("rnd_starve1", 64'(w1 > MB + 1), 64'(0));
         g0 = P0_GNT; g1 = P1_GNT;
         next_cycle();
         if (g0) P0_REQ = 0;
         if (g1) P1_REQ = 0;
      end
      idle_in();
      next_cycle();
      next_cycle();
      for (int i = 0; i < 32; i++) chk("rnd_mem", 64'(mem[i]), 64'(sh[i]));

      $display("[TB] %0d tests run, %0d failed", ntests, nfail);
      $finish;
   end

endmodule
